// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified memory-port arbiter: FSM states and owner codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_LDR  = 2'b10;

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter that times the memory read latency; done marks the last wait cycle.
module arb_lat_counter #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int CW = $clog2(MEM_LAT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(MEM_LAT);
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // cnt holds the wait cycles remaining including the current one
  assign done = (cnt == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU and the program loader: CPU priority with a
// burst limit, one latched access at a time, fixed read latency, one-cycle ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 8,
  parameter int MEM_LAT   = 1,
  parameter int CPU_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WIDTH-1:0]  cpu_wdata,
  output logic [WIDTH-1:0]  cpu_rdata,
  output logic              cpu_ack,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [WIDTH-1:0]  ldr_wdata,
  output logic [WIDTH-1:0]  ldr_rdata,
  output logic              ldr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [1:0]        owner
);

  // Handshake: a requester holds req (with we/addr/wdata stable) until its one-cycle ack;
  // signals are sampled only in IDLE at grant, and req must drop or change after ack.

  localparam int BW = $clog2(CPU_BURST + 1);

  arb_state_t        state, state_nxt;
  logic [1:0]        owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [WIDTH-1:0]  rdata_q;
  logic [BW-1:0]     burst_cnt;
  logic              grant_cpu, grant_ldr;
  logic              lat_done;

  always_comb begin
    grant_cpu = 1'b0;
    grant_ldr = 1'b0;
    if (state == S_IDLE) begin
      if (cpu_req && ldr_req) begin
        if (burst_cnt == BW'(CPU_BURST)) grant_ldr = 1'b1;
        else                             grant_cpu = 1'b1;
      end else begin
        grant_cpu = cpu_req;
        grant_ldr = ldr_req;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_cpu || grant_ldr) state_nxt = S_ACC;
      S_ACC:   state_nxt = we_q ? S_RESP : S_WAIT;
      S_WAIT:  if (lat_done) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_cpu) begin
      owner_q <= OWN_CPU;
      we_q    <= cpu_we;
      addr_q  <= cpu_addr;
      wdata_q <= cpu_wdata;
    end else if (grant_ldr) begin
      owner_q <= OWN_LDR;
      we_q    <= ldr_we;
      addr_q  <= ldr_addr;
      wdata_q <= ldr_wdata;
    end
  end

  // Counts CPU grants taken while the loader waits; a full count hands the next tie to it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (grant_ldr) begin
      burst_cnt <= '0;
    end else if (grant_cpu) begin
      if (!ldr_req)                          burst_cnt <= '0;
      else if (burst_cnt != BW'(CPU_BURST)) burst_cnt <= burst_cnt + 1'b1;
    end
  end

  // Cleared at grant so that a write completes with zero read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (grant_cpu || grant_ldr) begin
      rdata_q <= '0;
    end else if (state == S_WAIT && lat_done) begin
      rdata_q <= mem_rdata;
    end
  end

  arb_lat_counter #(
    .MEM_LAT(MEM_LAT)
  ) u_lat (
    .clk  (clk),
    .rst  (rst),
    .load (state == S_ACC),
    .dec  (state == S_WAIT),
    .done (lat_done)
  );

  assign mem_en    = (state == S_ACC);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign owner     = (state == S_IDLE) ? OWN_NONE : owner_q;
  assign cpu_ack   = (state == S_RESP) && (owner_q == OWN_CPU);
  assign ldr_ack   = (state == S_RESP) && (owner_q == OWN_LDR);
  assign cpu_rdata = cpu_ack ? rdata_q : '0;
  assign ldr_rdata = ldr_ack ? rdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: latency-1 instance for function/arbitration, latency-3 for abort.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int W  = 32;
  localparam int AW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst3 = 1'b1;
  always #5 clk = ~clk;

  logic          cpu_req = 1'b0, cpu_we = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0, ldr_addr = '0;
  logic [W-1:0]  cpu_wdata = '0, ldr_wdata = '0;
  logic [W-1:0]  cpu_rdata, ldr_rdata, mem_wdata, mem_rdata;
  logic          cpu_ack, ldr_ack, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0]    owner;

  logic          c3_req = 1'b0, c3_we = 1'b0;
  logic [AW-1:0] c3_addr = '0;
  logic [W-1:0]  c3_wdata = '0;
  logic [W-1:0]  c3_rdata, l3_rdata, m3_wdata, m3_rdata;
  logic          c3_ack, l3_ack, m3_en, m3_we;
  logic [AW-1:0] m3_addr;
  logic [1:0]    owner3;

  mem_port_arbiter #(.WIDTH(W), .ADDR_W(AW), .MEM_LAT(1), .CPU_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  mem_port_arbiter #(.WIDTH(W), .ADDR_W(AW), .MEM_LAT(3), .CPU_BURST(4)) dut3 (
    .clk(clk), .rst(rst3),
    .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
    .cpu_rdata(c3_rdata), .cpu_ack(c3_ack),
    .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr('0), .ldr_wdata('0),
    .ldr_rdata(l3_rdata), .ldr_ack(l3_ack),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
    .mem_rdata(m3_rdata), .owner(owner3)
  );

  function automatic logic [W-1:0] init_word(input int a);
    if (a == 16) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 | W'(a * 7 + 1);
  endfunction

  // memory model, latency 1; garbage outside the valid read cycle
  logic [W-1:0] mem [256];
  logic [W-1:0] rd_d = '0;
  logic         rd_v = 1'b0;
  logic         init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      init_done <= 1'b1;
    end else begin
      rd_v <= mem_en && !mem_we;
      if (mem_en) rd_d <= mem[mem_addr];
      if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = rd_v ? rd_d : 32'hBAD0_BAD0;

  // memory model, latency 3, returns an address-derived word
  logic [2:0]   v3 = '0;
  logic [W-1:0] d3_0 = '0, d3_1 = '0, d3_2 = '0;
  always @(posedge clk) begin
    v3   <= {v3[1:0], m3_en && !m3_we};
    d3_0 <= {24'h5A5A5A, m3_addr};
    d3_1 <= d3_0;
    d3_2 <= d3_1;
  end
  assign m3_rdata = v3[2] ? d3_2 : 32'hBAD3_BAD3;

  // scoreboard
  logic [W-1:0] ref_mem [256];
  logic [W-1:0] cpu_exp_q[$];
  logic [W-1:0] ldr_exp_q[$];
  logic [W-1:0] c3_exp_q[$];
  logic [W-1:0] grant_log[$];
  logic [1:0]   prev_owner = OWN_NONE;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] gl(input logic [1:0] own, input int b);
    return W'({own, 8'(b)});
  endfunction

  always @(negedge clk) begin
    if (cpu_ack) begin
      if (cpu_exp_q.size() == 0) check("cpu_ack_spurious", W'(cpu_ack), '0);
      else check("cpu_rdata", cpu_rdata, cpu_exp_q.pop_front());
    end
    if (ldr_ack) begin
      if (ldr_exp_q.size() == 0) check("ldr_ack_spurious", W'(ldr_ack), '0);
      else check("ldr_rdata", ldr_rdata, ldr_exp_q.pop_front());
    end
    if (cpu_ack || ldr_ack) check("ack_exclusive", W'(cpu_ack & ldr_ack), '0);
    if (mem_we) check("mem_we_gated", W'(mem_en), W'(1));
    if (owner != OWN_NONE && prev_owner == OWN_NONE)
      grant_log.push_back(gl(owner, int'(dut.burst_cnt)));
    prev_owner <= owner;
    if (c3_ack) begin
      if (c3_exp_q.size() == 0) check("c3_ack_spurious", W'(c3_ack), '0);
      else check("c3_rdata", c3_rdata, c3_exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic access(input logic is_ldr, input logic we, input logic [AW-1:0] addr,
                        input logic [W-1:0] wdata, input int exp_lat);
    logic [W-1:0] e;
    logic got;
    int c;
    @(posedge clk); #1;
    e = we ? '0 : ref_mem[addr];
    if (we) ref_mem[addr] = wdata;
    if (is_ldr) begin
      ldr_we = we; ldr_addr = addr; ldr_wdata = wdata; ldr_req = 1'b1;
      ldr_exp_q.push_back(e);
    end else begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
      cpu_exp_q.push_back(e);
    end
    c = 0;
    got = 1'b0;
    while (c < 60) begin
      @(negedge clk);
      if (c == 1 && exp_lat >= 0) begin
        check("acc_mem_en", W'(mem_en), W'(1));
        check("acc_mem_we", W'(mem_we), W'(we));
        check("acc_mem_addr", W'(mem_addr), W'(addr));
        if (we) check("acc_mem_wdata", mem_wdata, wdata);
      end
      got = is_ldr ? ldr_ack : cpu_ack;
      if (got) break;
      c++;
    end
    if (exp_lat >= 0) check(is_ldr ? "ldr_latency" : "cpu_latency", W'(c), W'(exp_lat));
    else              check(is_ldr ? "ldr_ack_seen" : "cpu_ack_seen", W'(got), W'(1));
    @(posedge clk); #1;
    if (is_ldr) ldr_req = 1'b0;
    else        cpu_req = 1'b0;
  endtask

  // CPU keeps req high, replacing the address in the IDLE cycle after each ack
  task automatic cpu_stream(input int n);
    logic [AW-1:0] a;
    int c;
    @(posedge clk); #1;
    cpu_we = 1'b0;
    cpu_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      a = AW'($urandom_range(32, 63));
      cpu_addr = a;
      cpu_exp_q.push_back(ref_mem[a]);
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!cpu_ack && c < 80);
      check("stream_ack", W'(cpu_ack), W'(1));
      @(posedge clk); #1;
    end
    cpu_req = 1'b0;
  endtask

  task automatic access3(input logic we, input logic [AW-1:0] a, input int exp_lat);
    int c;
    @(posedge clk); #1;
    c3_we = we; c3_addr = a; c3_wdata = $urandom(); c3_req = 1'b1;
    c3_exp_q.push_back(we ? '0 : {24'h5A5A5A, a});
    c = 0;
    while (c < 40) begin
      @(negedge clk);
      if (c3_ack) break;
      c++;
    end
    check("c3_latency", W'(c), W'(exp_lat));
    @(posedge clk); #1;
    c3_req = 1'b0;
  endtask

  task automatic check_grants(input string tag, input logic [W-1:0] exp [], input int n);
    check({tag, "_count"}, W'(grant_log.size()), W'(n));
    for (int i = 0; i < n && i < grant_log.size(); i++) check(tag, grant_log[i], exp[i]);
  endtask

  initial begin
    logic [W-1:0] exp_g [];
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", W'({cpu_ack, ldr_ack, mem_en, mem_we, owner}), '0);
    check("reset_rdata", cpu_rdata | ldr_rdata, '0);
    check("reset_burst", W'(dut.burst_cnt), '0);
    rst = 1'b0;
    rst3 = 1'b0;

    // CPU read latency 3 and loader write then CPU read-back
    access(1'b0, 1'b0, 8'h10, '0, 3);
    access(1'b1, 1'b1, 8'h04, 32'h1234_5678, 2);
    access(1'b0, 1'b0, 8'h04, '0, 3);

    // simultaneous requests: CPU first, loader next
    grant_log.delete();
    fork
      access(1'b0, 1'b0, 8'h21, '0, 3);
      access(1'b1, 1'b0, 8'h22, '0, -1);
    join
    exp_g = new[2];
    exp_g[0] = gl(OWN_CPU, 1);
    exp_g[1] = gl(OWN_LDR, 0);
    check_grants("tie_grants", exp_g, 2);

    // CPU burst limit lets the loader in on the fifth grant
    grant_log.delete();
    fork
      cpu_stream(5);
      access(1'b1, 1'b0, 8'h70, '0, -1);
    join
    exp_g = new[6];
    exp_g[0] = gl(OWN_CPU, 1);
    exp_g[1] = gl(OWN_CPU, 2);
    exp_g[2] = gl(OWN_CPU, 3);
    exp_g[3] = gl(OWN_CPU, 4);
    exp_g[4] = gl(OWN_LDR, 0);
    exp_g[5] = gl(OWN_CPU, 0);
    check_grants("burst_grants", exp_g, 6);

    // random sequential traffic, small address range for read-after-write hits
    for (int i = 0; i < 16; i++) begin
      logic is_l, we;
      is_l = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      access(is_l, we, AW'($urandom_range(0, 15)), $urandom(), we ? 2 : 3);
    end

    // async reset during an access: outputs drop at once, no ack afterwards
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 8'h20; cpu_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_mem_en", W'(mem_en), W'(1));
    #2 rst = 1'b1;
    #1;
    check("async_rst_outs", W'({cpu_ack, ldr_ack, mem_en, mem_we, owner}), '0);
    check("async_rst_rdata", cpu_rdata | ldr_rdata, '0);
    check("async_rst_burst", W'(dut.burst_cnt), '0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_state", W'(dut.state), W'(S_IDLE));
    access(1'b0, 1'b0, 8'h10, '0, 3);

    // latency-3 instance: abort a read in WAIT, then fresh accesses
    @(posedge clk); #1;
    c3_we = 1'b0; c3_addr = 8'h33; c3_req = 1'b1;
    repeat (3) @(negedge clk);
    check("c3_in_wait", W'(dut3.state), W'(S_WAIT));
    #2 rst3 = 1'b1;
    #1;
    check("c3_rst_outs", W'({c3_ack, m3_en, owner3}), '0);
    c3_req = 1'b0;
    @(posedge clk); #1;
    rst3 = 1'b0;
    repeat (10) @(negedge clk);
    access3(1'b0, 8'h44, 5);
    access3(1'b1, 8'h45, 2);
    access3(1'b0, 8'hA7, 5);

    repeat (4) @(negedge clk);
    check("cpu_q_drained", W'(cpu_exp_q.size()), '0);
    check("ldr_q_drained", W'(ldr_exp_q.size()), '0);
    check("c3_q_drained", W'(c3_exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", n_checks, 0);
    $fatal(1, "time limit");
  end

endmodule
